// File: rtl/dummy_flop_pkg.sv
// Shared constants and types for the dummy_flop delay-line test vehicle.
// Used by dummy_flop (stage chain) and dummy_flop_edge (edge detect / counter).
package dummy_flop_pkg;

  localparam int unsigned DEFAULT_STAGES = 1;
  localparam int unsigned MAX_STAGES     = 16;
  localparam int unsigned DEFAULT_CNT_W  = 8;
  localparam int unsigned MIN_CNT_W      = 2;
  localparam int unsigned MAX_CNT_W      = 32;

  typedef logic [MAX_STAGES-1:0] stage_vec_t;

  // Replicates the reset value across the widest possible chain.
  function automatic stage_vec_t stage_fill(input logic v);
    return {MAX_STAGES{v}};
  endfunction

endpackage

// File: rtl/dummy_flop_edge.sv
// Edge-history flop plus registered-q rise/fall decode for dummy_flop.
// Optional saturating transition counter when DUMMY_EDGE_CNT_EN is defined.
module dummy_flop_edge
  import dummy_flop_pkg::*;
#(
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             q,
  output logic             q_rise,
  output logic             q_fall
`ifdef DUMMY_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
`endif
);

  if ((CNT_W < MIN_CNT_W) || (CNT_W > MAX_CNT_W)) begin : g_bad_cnt_w
    $error("dummy_flop_edge: CNT_W=%0d outside %0d..%0d", CNT_W, MIN_CNT_W, MAX_CNT_W);
  end

  logic q_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_d <= RESET_VAL;
    end else begin
      q_d <= q;
    end
  end

  // Both terms come straight from flops, so the pulses carry no hazards.
  assign q_rise = q & ~q_d;
  assign q_fall = ~q & q_d;

`ifdef DUMMY_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if ((q_rise | q_fall) && !cnt_sat) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign cnt_sat  = &cnt;
  assign edge_cnt = cnt;
`endif

endmodule

// File: rtl/dummy_flop.sv
// Parameterised single-bit registered delay line with registered edge pulses.
// Define DUMMY_EDGE_CNT_EN to add the edge_cnt / cnt_sat transition counter.
module dummy_flop
  import dummy_flop_pkg::*;
#(
  parameter int unsigned STAGES    = DEFAULT_STAGES,
  parameter logic        RESET_VAL = 1'b0,
  parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d,
  output logic             q,
  output logic             q_rise,
  output logic             q_fall
`ifdef DUMMY_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
`endif
);

  if ((STAGES < 1) || (STAGES > MAX_STAGES)) begin : g_bad_stages
    $error("dummy_flop: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
  end

  localparam stage_vec_t RST_VEC = stage_fill(RESET_VAL);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= RST_VEC[STAGES-1:0];
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // q is the last flop itself; nothing may sit between it and the port.
  assign q = stage[STAGES-1];

  dummy_flop_edge #(
    .RESET_VAL (RESET_VAL),
    .CNT_W     (CNT_W)
  ) u_edge (
    .clk      (clk),
    .rstn     (rstn),
    .q        (q),
    .q_rise   (q_rise),
    .q_fall   (q_fall)
`ifdef DUMMY_EDGE_CNT_EN
    ,
    .edge_cnt (edge_cnt),
    .cnt_sat  (cnt_sat)
`endif
  );

endmodule

// File: tb/tb_dummy_flop.sv
// Directed self-checking bench for dummy_flop: two STAGES=1 instances sharing d,
// one STAGES=4 instance on its own input; counter checks when DUMMY_EDGE_CNT_EN is set.
module tb_dummy_flop;

  logic clk;
  logic rstn;
  logic d;
  logic d4;

  logic q_a, r_a, f_a;
  logic q_b, r_b, f_b;
  logic q_c, r_c, f_c;

`ifdef DUMMY_EDGE_CNT_EN
  logic [1:0] cnt_a;
  logic       sat_a;
  logic [7:0] cnt_b;
  logic       sat_b;
  logic [7:0] cnt_c;
  logic       sat_c;
`endif

  int total = 0;
  int bad   = 0;

  dummy_flop #(.STAGES(1), .RESET_VAL(1'b0), .CNT_W(2)) u_a (
    .clk(clk), .rstn(rstn), .d(d), .q(q_a), .q_rise(r_a), .q_fall(f_a)
`ifdef DUMMY_EDGE_CNT_EN
    , .edge_cnt(cnt_a), .cnt_sat(sat_a)
`endif
  );

  dummy_flop #(.STAGES(1)) u_b (
    .clk(clk), .rstn(rstn), .d(d), .q(q_b), .q_rise(r_b), .q_fall(f_b)
`ifdef DUMMY_EDGE_CNT_EN
    , .edge_cnt(cnt_b), .cnt_sat(sat_b)
`endif
  );

  dummy_flop #(.STAGES(4)) u_c (
    .clk(clk), .rstn(rstn), .d(d4), .q(q_c), .q_rise(r_c), .q_fall(f_c)
`ifdef DUMMY_EDGE_CNT_EN
    , .edge_cnt(cnt_c), .cnt_sat(sat_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both STAGES=1 instances must match the same expectation every time.
  task automatic chk_ab(input string tag, input logic eq, input logic er, input logic ef);
    chk({tag, "_qa"}, {31'd0, q_a}, {31'd0, eq});
    chk({tag, "_ra"}, {31'd0, r_a}, {31'd0, er});
    chk({tag, "_fa"}, {31'd0, f_a}, {31'd0, ef});
    chk({tag, "_qb"}, {31'd0, q_b}, {31'd0, eq});
    chk({tag, "_rb"}, {31'd0, r_b}, {31'd0, er});
    chk({tag, "_fb"}, {31'd0, f_b}, {31'd0, ef});
  endtask

  task automatic chk_c(input string tag, input logic eq, input logic er, input logic ef);
    chk({tag, "_qc"}, {31'd0, q_c}, {31'd0, eq});
    chk({tag, "_rc"}, {31'd0, r_c}, {31'd0, er});
    chk({tag, "_fc"}, {31'd0, f_c}, {31'd0, ef});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int exp_cnt_a [6] = '{0, 1, 2, 3, 3, 3};
  int exp_sat_a [6] = '{0, 0, 0, 1, 1, 1};
  int exp_cnt_b [6] = '{0, 1, 2, 3, 4, 5};

  initial begin
    rstn = 1'b1;
    d    = 1'b0;
    d4   = 1'b0;
    #1 rstn = 1'b0;
    #1;
    // reset forced with no clock edge yet
    chk_ab("rst0", 1'b0, 1'b0, 1'b0);
    chk_c("rst0", 1'b0, 1'b0, 1'b0);
`ifdef DUMMY_EDGE_CNT_EN
    chk("rst0_cnta", {30'd0, cnt_a}, 32'd0);
    chk("rst0_sata", {31'd0, sat_a}, 32'd0);
`endif
    tick;                                   // 6 ns, edge at 5 while in reset
    chk_ab("rst1", 1'b0, 1'b0, 1'b0);
    @(posedge clk);                         // 15 ns
    #1 rstn = 1'b1;
    chk_ab("rel", 1'b0, 1'b0, 1'b0);

    tick;                                   // 26: captured d=0
    chk_ab("t25", 1'b0, 1'b0, 1'b0);
    d = 1'b1; d4 = 1'b1;
    tick;                                   // 36
    chk_ab("t35", 1'b1, 1'b1, 1'b0);
    chk_c("t35", 1'b0, 1'b0, 1'b0);
    d = 1'b0; d4 = 1'b0;
    tick;                                   // 46
    chk_ab("t45", 1'b0, 1'b0, 1'b1);
    chk_c("t45", 1'b0, 1'b0, 1'b0);
    d = 1'b1;
    tick;                                   // 56
    chk_ab("t55", 1'b1, 1'b1, 1'b0);
    chk_c("t55", 1'b0, 1'b0, 1'b0);
    tick;                                   // 66: 4-stage pulse arrives
    chk_ab("t65", 1'b1, 1'b0, 1'b0);
    chk_c("t65", 1'b1, 1'b1, 1'b0);
`ifdef DUMMY_EDGE_CNT_EN
    chk("t65_cnta", {30'd0, cnt_a}, 32'd3);
    chk("t65_sata", {31'd0, sat_a}, 32'd1);
    chk("t65_cntb", {24'd0, cnt_b}, 32'd3);
    chk("t65_satb", {31'd0, sat_b}, 32'd0);
`endif
    tick;                                   // 76
    chk_ab("t75", 1'b1, 1'b0, 1'b0);
    chk_c("t75", 1'b0, 1'b0, 1'b1);
`ifdef DUMMY_EDGE_CNT_EN
    chk("t75_cntb", {24'd0, cnt_b}, 32'd3);
    chk("t75_cntc", {24'd0, cnt_c}, 32'd1);
`endif
    tick;                                   // 86
    chk_c("t85", 1'b0, 1'b0, 1'b0);

    // fill the pipelines with ones, then reset between edges
    d = 1'b1; d4 = 1'b1;
    tick; tick; tick; tick;                 // 126
    chk_c("fill", 1'b1, 1'b1, 1'b0);
    chk_ab("fill", 1'b1, 1'b0, 1'b0);
    #2 rstn = 1'b0;                         // 128, mid-cycle
    #1;
    chk_ab("arst", 1'b0, 1'b0, 1'b0);
    chk_c("arst", 1'b0, 1'b0, 1'b0);
`ifdef DUMMY_EDGE_CNT_EN
    chk("arst_cnta", {30'd0, cnt_a}, 32'd0);
    chk("arst_sata", {31'd0, sat_a}, 32'd0);
    chk("arst_cntc", {24'd0, cnt_c}, 32'd0);
`endif
    @(posedge clk);                         // 135
    #1 rstn = 1'b1;
    d = 1'b0; d4 = 1'b0;

    tick;                                   // 146
    chk_ab("post", 1'b0, 1'b0, 1'b0);
    chk_c("post", 1'b0, 1'b0, 1'b0);

    // toggle d every cycle: alternating pulses, counter saturation
    d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i % 2 == 0) chk_ab($sformatf("tog%0d", i), 1'b1, 1'b1, 1'b0);
      else            chk_ab($sformatf("tog%0d", i), 1'b0, 1'b0, 1'b1);
      // in-flight ones from before the reset must never reach q
      chk({"flush", $sformatf("%0d", i), "_qc"}, {31'd0, q_c}, 32'd0);
`ifdef DUMMY_EDGE_CNT_EN
      chk($sformatf("tog%0d_cnta", i), {30'd0, cnt_a}, exp_cnt_a[i]);
      chk($sformatf("tog%0d_sata", i), {31'd0, sat_a}, exp_sat_a[i]);
      chk($sformatf("tog%0d_cntb", i), {24'd0, cnt_b}, exp_cnt_b[i]);
`endif
      d = ~d;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dummy_flop.md
Name: dummy_flop

Overview:
- Single-bit registered delay line: input d is sampled on rising clk and appears on q after a parameterised number of cycles.
- Registered edge-detect pulses on q are provided alongside q.
- Used as a small gate-level timing/annotation test vehicle; several instances may share clk/rstn/d and are checked for identical q.
- Default configuration is a single asynchronously reset D flip-flop.

Parameters:
- STAGES, 1, number of flop stages between d and q; legal range 1..16, elaborate-time error outside it.
- RESET_VAL, 1'b0, value loaded into every stage and into the edge-history flop on reset.
- CNT_W, 8, edge counter width; only used when DUMMY_EDGE_CNT_EN is defined; legal 2..32.

Ports:
- clk  input  1  single clock, rising-edge active.
- rstn  input  1  asynchronous, active-low reset.
- d  input  1  data input, sampled every rising clk.
- q  output  1  delayed data; directly the last flop stage, with no logic after it.
- q_rise  output  1  one-cycle pulse when q transitions 0->1.
- q_fall  output  1  one-cycle pulse when q transitions 1->0.
- edge_cnt  output  CNT_W  number of q transitions; present only with DUMMY_EDGE_CNT_EN.
- cnt_sat  output  1  edge_cnt is saturated; present only with DUMMY_EDGE_CNT_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn).
- Pipeline:
  - stage[0] <= d; stage[i] <= stage[i-1]; q = stage[STAGES-1].
  - Latency is exactly STAGES rising edges from d sampled to q. STAGES=1 is a plain DFF.
- Reset:
  - rstn low immediately forces all stages to RESET_VAL, so q=RESET_VAL with no clock needed.
  - Edge-history flop q_d is forced to RESET_VAL, so q_rise=q_fall=0.
  - edge_cnt=0 and cnt_sat=0.
  - Reset asserted mid-stream discards all in-flight bits.
  - Deassertion is not synchronised internally. The first sampling edge is the first rising clk with rstn high; d on that edge is captured.
- Edge detect:
  - q_d <= q every cycle.
  - q_rise = q & ~q_d; q_fall = ~q & q_d (combinational from flops, glitch-free in RTL).
  - Each pulse is high for exactly one cycle per q transition. They are never simultaneously high.
- No enable and no bypass: d changes every cycle propagate unfiltered; back-to-back toggles give alternating rise/fall pulses every cycle.
- d held constant: q settles after STAGES cycles and stays; no pulses.
- X on d propagates to q; no X-masking logic.

Optional Feature:
- Macro DUMMY_EDGE_CNT_EN.
- Defined:
  - Adds edge_cnt and cnt_sat ports.
  - edge_cnt increments by 1 in the cycle after any q_rise or q_fall.
  - Saturates at 2^CNT_W-1, never wraps.
  - cnt_sat = (edge_cnt == all ones).
  - Cleared only by rstn.
- Undefined: ports, counter and saturation logic are absent; all other behaviour is identical.

Decomposition:
- Package dummy_flop_pkg holds:
  - DEFAULT_STAGES=1, MAX_STAGES=16.
  - DEFAULT_CNT_W=8.
  - typedef logic [MAX_STAGES-1:0] stage_vec_t.
- One natural sub-module, dummy_flop_edge: q_d flop, rise/fall decode and the optional counter. The top holds only the stage chain.

Test Plan:
- Reset: rstn=0 for 15 ns with d=0 and 10 ns clk period -> q=0, q_rise=q_fall=0, edge_cnt=0 throughout reset.
- Defaults (STAGES=1), run after rstn=1 at 15 ns:
  - d=1 at 25 ns -> q=1 after the 35 ns edge.
  - d=0 at 35 ns -> q=0 after the 45 ns edge.
  - d=1 at 45 ns -> q=1 after the 55 ns edge.
  - q_rise pulses for one cycle after each 0->1, q_fall after the 1->0.
- Two instances with shared clk/rstn/d -> q identical on every cycle.
- STAGES=4: single-cycle d pulse of 1 -> q high for exactly one cycle, 4 edges later; one q_rise then one q_fall.
- Async reset: assert rstn low between clock edges while pipeline holds 1s -> q drops to 0 immediately, without waiting for a clock edge.
- DUMMY_EDGE_CNT_EN with CNT_W=2, toggling d every cycle -> edge_cnt counts 1,2,3 then holds at 3 with cnt_sat=1.
